// File: rtl/alu_rs_gen2.sv
// alu_rs_gen2: reservation station for ALU instructions.
// Holds DEPTH dispatched instructions, wakes their operands from the common
// data bus and issues the oldest ready entry into a single issue register.
// Age is tracked with a pairwise matrix: older_reg[j][i] = 1 means entry j
// was dispatched before entry i. The matrix is only meaningful between
// valid entries.
module alu_rs_gen2 #(
  parameter int DEPTH  = 8,
  parameter int N_CDB  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clear,
  input  logic                       we_i,
  input  logic [OP_W-1:0]            op_i,
  input  logic [DATA_W-1:0]          imm_i,
  input  logic [DATA_W-1:0]          pc_i,
  input  logic [TAG_W-1:0]           des_i,
  input  logic                       reg1_valid_i,
  input  logic                       reg2_valid_i,
  input  logic [TAG_W-1:0]           reg1_tag_i,
  input  logic [TAG_W-1:0]           reg2_tag_i,
  input  logic [DATA_W-1:0]          reg1_data_i,
  input  logic [DATA_W-1:0]          reg2_data_i,
  input  logic [N_CDB-1:0]           cdb_en_i,
  input  logic [N_CDB*TAG_W-1:0]     cdb_tag_i,
  input  logic [N_CDB*DATA_W-1:0]    cdb_data_i,
  input  logic                       alu_ready_i,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] free_cnt_o,
  output logic                       ALU_en_o,
  output logic [OP_W-1:0]            op_o,
  output logic [DATA_W-1:0]          imm_o,
  output logic [DATA_W-1:0]          pc_o,
  output logic [TAG_W-1:0]           des_o,
  output logic [DATA_W-1:0]          reg1_o,
  output logic [DATA_W-1:0]          reg2_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Returns {hit, data}; the lowest-index matching channel wins because the
  // loop walks from the highest channel down and later matches overwrite.
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [TAG_W-1:0]        tag,
    input logic [N_CDB-1:0]        en,
    input logic [N_CDB*TAG_W-1:0]  tags,
    input logic [N_CDB*DATA_W-1:0] data
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int k = N_CDB-1; k >= 0; k--) begin
      if (en[k] && (tags[k*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, data[k*DATA_W +: DATA_W]};
      end
    end
    return res;
  endfunction

  // Entry state
  logic [DEPTH-1:0]  valid_reg;
  logic [DEPTH-1:0]  src1_valid_reg;
  logic [DEPTH-1:0]  src2_valid_reg;
  logic [DEPTH-1:0]  older_reg     [DEPTH];
  logic [OP_W-1:0]   op_reg        [DEPTH];
  logic [DATA_W-1:0] imm_reg       [DEPTH];
  logic [DATA_W-1:0] pc_reg        [DEPTH];
  logic [TAG_W-1:0]  des_reg       [DEPTH];
  logic [TAG_W-1:0]  src1_tag_reg  [DEPTH];
  logic [TAG_W-1:0]  src2_tag_reg  [DEPTH];
  logic [DATA_W-1:0] src1_data_reg [DEPTH];
  logic [DATA_W-1:0] src2_data_reg [DEPTH];

  // Issue register
  logic              alu_en_reg;
  logic [OP_W-1:0]   op_out_reg;
  logic [DATA_W-1:0] imm_out_reg;
  logic [DATA_W-1:0] pc_out_reg;
  logic [TAG_W-1:0]  des_out_reg;
  logic [DATA_W-1:0] reg1_out_reg;
  logic [DATA_W-1:0] reg2_out_reg;

  // Combinational helpers
  logic [DATA_W:0]   wake1 [DEPTH];
  logic [DATA_W:0]   wake2 [DEPTH];
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  pick;
  logic [DATA_W:0]   byp1;
  logic [DATA_W:0]   byp2;
  logic [IDX_W-1:0]  alloc_idx;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_any;
  logic [CNT_W-1:0]  free_cnt;
  logic              advance;
  logic              issue_load;
  logic              disp_fire;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic blocked;

      assign wake1[gi] = cdb_lookup(src1_tag_reg[gi], cdb_en_i, cdb_tag_i, cdb_data_i);
      assign wake2[gi] = cdb_lookup(src2_tag_reg[gi], cdb_en_i, cdb_tag_i, cdb_data_i);
      assign ready[gi] = valid_reg[gi] & src1_valid_reg[gi] & src2_valid_reg[gi];

      // An entry is blocked when some other ready entry is older than it
      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          if ((j != gi) && ready[j] && older_reg[j][gi]) begin
            blocked = 1'b1;
          end
        end
      end

      assign pick[gi] = ready[gi] & ~blocked;
    end
  endgenerate

  // Same-cycle bypass for operands arriving with the dispatch
  assign byp1 = cdb_lookup(reg1_tag_i, cdb_en_i, cdb_tag_i, cdb_data_i);
  assign byp2 = cdb_lookup(reg2_tag_i, cdb_en_i, cdb_tag_i, cdb_data_i);

  // Lowest-index free entry, taken from registered state only
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Encode the one-hot oldest-ready pick into an index
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_any = |pick;

  // Population count of free entries
  always_comb begin
    free_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      free_cnt = free_cnt + CNT_W'(!valid_reg[i]);
    end
  end

  assign free_cnt_o = free_cnt;
  assign full_o     = (free_cnt == '0);

  assign advance    = rdy & ~clear;
  assign issue_load = advance & (~alu_en_reg | alu_ready_i);
  assign disp_fire  = advance & we_i & ~full_o;

  // Valid bits, age matrix and the issue register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg      <= '0;
      src1_valid_reg <= '0;
      src2_valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        older_reg[i] <= '0;
      end
      alu_en_reg   <= 1'b0;
      op_out_reg   <= '0;
      imm_out_reg  <= '0;
      pc_out_reg   <= '0;
      des_out_reg  <= '0;
      reg1_out_reg <= '0;
      reg2_out_reg <= '0;
    end else if (clear) begin
      valid_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        older_reg[i] <= '0;
      end
      alu_en_reg <= 1'b0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_reg[i] && !src1_valid_reg[i] && wake1[i][DATA_W]) begin
          src1_valid_reg[i] <= 1'b1;
        end
        if (valid_reg[i] && !src2_valid_reg[i] && wake2[i][DATA_W]) begin
          src2_valid_reg[i] <= 1'b1;
        end
      end
      if (issue_load) begin
        alu_en_reg <= sel_any;
        if (sel_any) begin
          valid_reg[sel_idx] <= 1'b0;
          op_out_reg         <= op_reg[sel_idx];
          imm_out_reg        <= imm_reg[sel_idx];
          pc_out_reg         <= pc_reg[sel_idx];
          des_out_reg        <= des_reg[sel_idx];
          reg1_out_reg       <= src1_data_reg[sel_idx];
          reg2_out_reg       <= src2_data_reg[sel_idx];
        end
      end
      if (disp_fire) begin
        valid_reg[alloc_idx]      <= 1'b1;
        src1_valid_reg[alloc_idx] <= reg1_valid_i | byp1[DATA_W];
        src2_valid_reg[alloc_idx] <= reg2_valid_i | byp2[DATA_W];
        // New entry is younger than every existing entry
        for (int j = 0; j < DEPTH; j++) begin
          older_reg[j][alloc_idx] <= 1'b1;
        end
        older_reg[alloc_idx] <= '0;
      end
    end
  end

  // Entry payload and operand data; no reset needed since valid bits gate use
  always_ff @(posedge clk) begin
    if (advance) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_reg[i] && !src1_valid_reg[i] && wake1[i][DATA_W]) begin
          src1_data_reg[i] <= wake1[i][DATA_W-1:0];
        end
        if (valid_reg[i] && !src2_valid_reg[i] && wake2[i][DATA_W]) begin
          src2_data_reg[i] <= wake2[i][DATA_W-1:0];
        end
      end
      if (disp_fire) begin
        op_reg[alloc_idx]        <= op_i;
        imm_reg[alloc_idx]       <= imm_i;
        pc_reg[alloc_idx]        <= pc_i;
        des_reg[alloc_idx]       <= des_i;
        src1_tag_reg[alloc_idx]  <= reg1_tag_i;
        src2_tag_reg[alloc_idx]  <= reg2_tag_i;
        src1_data_reg[alloc_idx] <= reg1_valid_i ? reg1_data_i : byp1[DATA_W-1:0];
        src2_data_reg[alloc_idx] <= reg2_valid_i ? reg2_data_i : byp2[DATA_W-1:0];
      end
    end
  end

  assign ALU_en_o = alu_en_reg;
  assign op_o     = op_out_reg;
  assign imm_o    = imm_out_reg;
  assign pc_o     = pc_out_reg;
  assign des_o    = des_out_reg;
  assign reg1_o   = reg1_out_reg;
  assign reg2_o   = reg2_out_reg;

endmodule

// File: tb/tb_alu_rs_gen2.sv
// tb_alu_rs_gen2: directed and randomized checks of alu_rs_gen2 against a
// sequence-number based reference model of the reservation station.
module tb_alu_rs_gen2;

  localparam int DEPTH  = 8;
  localparam int N_CDB  = 4;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic                      clk = 1'b0;
  logic                      rst, rdy, clear, we_i;
  logic [OP_W-1:0]           op_i;
  logic [DATA_W-1:0]         imm_i, pc_i;
  logic [TAG_W-1:0]          des_i;
  logic                      reg1_valid_i, reg2_valid_i;
  logic [TAG_W-1:0]          reg1_tag_i, reg2_tag_i;
  logic [DATA_W-1:0]         reg1_data_i, reg2_data_i;
  logic [N_CDB-1:0]          cdb_en_i;
  logic [N_CDB*TAG_W-1:0]    cdb_tag_i;
  logic [N_CDB*DATA_W-1:0]   cdb_data_i;
  logic                      alu_ready_i;
  logic                      full_o;
  logic [CNT_W-1:0]          free_cnt_o;
  logic                      ALU_en_o;
  logic [OP_W-1:0]           op_o;
  logic [DATA_W-1:0]         imm_o, pc_o;
  logic [TAG_W-1:0]          des_o;
  logic [DATA_W-1:0]         reg1_o, reg2_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit               v;
    int unsigned      seq;
    logic [OP_W-1:0]  op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [TAG_W-1:0] des;
    bit               v1;
    logic [TAG_W-1:0] t1;
    logic [DATA_W-1:0] d1;
    bit               v2;
    logic [TAG_W-1:0] t2;
    logic [DATA_W-1:0] d2;
  } ent_t;

  ent_t              m [DEPTH];
  bit                m_en;
  logic [OP_W-1:0]   m_op;
  logic [DATA_W-1:0] m_imm, m_pc, m_r1, m_r2;
  logic [TAG_W-1:0]  m_des;
  int unsigned       m_seq_ctr = 0;
  bit                m_issued;

  always #5 clk = ~clk;

  alu_rs_gen2 #(
    .DEPTH(DEPTH), .N_CDB(N_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .we_i(we_i),
    .op_i(op_i), .imm_i(imm_i), .pc_i(pc_i), .des_i(des_i),
    .reg1_valid_i(reg1_valid_i), .reg2_valid_i(reg2_valid_i),
    .reg1_tag_i(reg1_tag_i), .reg2_tag_i(reg2_tag_i),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .cdb_en_i(cdb_en_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .alu_ready_i(alu_ready_i), .full_o(full_o), .free_cnt_o(free_cnt_o),
    .ALU_en_o(ALU_en_o), .op_o(op_o), .imm_o(imm_o), .pc_o(pc_o), .des_o(des_o),
    .reg1_o(reg1_o), .reg2_o(reg2_o)
  );

  // First enabled channel (scanning upward) carrying the tag
  function automatic bit cdb_find(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] d);
    d = '0;
    for (int k = 0; k < N_CDB; k++) begin
      if (cdb_en_i[k] && (cdb_tag_i[k*TAG_W +: TAG_W] === t)) begin
        d = cdb_data_i[k*DATA_W +: DATA_W];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int model_free();
    int n;
    n = 0;
    for (int i = 0; i < DEPTH; i++) if (!m[i].v) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
    m_en = 1'b0; m_op = '0; m_imm = '0; m_pc = '0; m_des = '0; m_r1 = '0; m_r2 = '0;
  endtask

  // One clock edge of reference behaviour, using inputs as presented at the edge
  task automatic model_step();
    int alloc, sel;
    logic [DATA_W-1:0] d;
    m_issued = 1'b0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 1'b0;
      m_en = 1'b0;
      return;
    end
    if (!rdy) return;
    alloc = -1;
    for (int i = 0; i < DEPTH; i++) if (!m[i].v) begin alloc = i; break; end
    sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v && m[i].v1 && m[i].v2) begin
        if (sel < 0) sel = i;
        else if (m[i].seq < m[sel].seq) sel = i;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v) begin
        if (!m[i].v1 && cdb_find(m[i].t1, d)) begin m[i].v1 = 1'b1; m[i].d1 = d; end
        if (!m[i].v2 && cdb_find(m[i].t2, d)) begin m[i].v2 = 1'b1; m[i].d2 = d; end
      end
    end
    if (!m_en || alu_ready_i) begin
      if (sel >= 0) begin
        m_en = 1'b1; m_op = m[sel].op; m_imm = m[sel].imm; m_pc = m[sel].pc;
        m_des = m[sel].des; m_r1 = m[sel].d1; m_r2 = m[sel].d2;
        m[sel].v = 1'b0; m_issued = 1'b1;
      end else begin
        m_en = 1'b0;
      end
    end
    if (we_i && alloc >= 0) begin
      m[alloc].v = 1'b1; m[alloc].seq = m_seq_ctr; m_seq_ctr++;
      m[alloc].op = op_i; m[alloc].imm = imm_i; m[alloc].pc = pc_i; m[alloc].des = des_i;
      m[alloc].v1 = reg1_valid_i; m[alloc].t1 = reg1_tag_i; m[alloc].d1 = reg1_data_i;
      m[alloc].v2 = reg2_valid_i; m[alloc].t2 = reg2_tag_i; m[alloc].d2 = reg2_data_i;
      if (!reg1_valid_i && cdb_find(reg1_tag_i, d)) begin m[alloc].v1 = 1'b1; m[alloc].d1 = d; end
      if (!reg2_valid_i && cdb_find(reg2_tag_i, d)) begin m[alloc].v2 = 1'b1; m[alloc].d2 = d; end
    end
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".en"},   DATA_W'(ALU_en_o),   DATA_W'(m_en));
    chk({tag, ".op"},   DATA_W'(op_o),       DATA_W'(m_op));
    chk({tag, ".imm"},  imm_o,               m_imm);
    chk({tag, ".pc"},   pc_o,                m_pc);
    chk({tag, ".des"},  DATA_W'(des_o),      DATA_W'(m_des));
    chk({tag, ".reg1"}, reg1_o,              m_r1);
    chk({tag, ".reg2"}, reg2_o,              m_r2);
    chk({tag, ".free"}, DATA_W'(free_cnt_o), DATA_W'(model_free()));
    chk({tag, ".full"}, DATA_W'(full_o),     DATA_W'(model_free() == 0));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
    if (m_issued)
      $display("issue %s: des=%0d op=0x%0h reg1=0x%0h reg2=0x%0h", tag, m_des, m_op, m_r1, m_r2);
  endtask

  task automatic idle();
    we_i = 1'b0; cdb_en_i = '0; clear = 1'b0; rdy = 1'b1;
  endtask

  task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] des,
                          input logic v1, input logic [TAG_W-1:0] t1, input logic [DATA_W-1:0] d1,
                          input logic v2, input logic [TAG_W-1:0] t2, input logic [DATA_W-1:0] d2);
    we_i = 1'b1; op_i = op; des_i = des; imm_i = $urandom; pc_i = $urandom;
    reg1_valid_i = v1; reg1_tag_i = t1; reg1_data_i = d1;
    reg2_valid_i = v2; reg2_tag_i = t2; reg2_data_i = d2;
  endtask

  task automatic set_cdb(input int k, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
    cdb_en_i[k] = 1'b1;
    cdb_tag_i[k*TAG_W +: TAG_W] = t;
    cdb_data_i[k*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; we_i = 1'b0; op_i = '0; imm_i = '0; pc_i = '0;
    des_i = '0; reg1_valid_i = 1'b0; reg2_valid_i = 1'b0; reg1_tag_i = '0; reg2_tag_i = '0;
    reg1_data_i = '0; reg2_data_i = '0; cdb_en_i = '0; cdb_tag_i = '0; cdb_data_i = '0;
    alu_ready_i = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("reset.free8", DATA_W'(free_cnt_o), 32'd8);
    rst = 1'b0;

    // Ready dispatch issues one cycle after acceptance
    set_disp(6'h05, 4'd3, 1'b1, 4'd0, 32'd10, 1'b1, 4'd0, 32'd20);
    tick("rd.disp");
    idle();
    tick("rd.issue");
    chk("rd.en", DATA_W'(ALU_en_o), 32'd1);
    chk("rd.reg1", reg1_o, 32'd10);
    chk("rd.reg2", reg2_o, 32'd20);
    chk("rd.des", DATA_W'(des_o), 32'd3);
    chk("rd.op", DATA_W'(op_o), 32'h05);
    tick("rd.after");
    chk("rd.en_low", DATA_W'(ALU_en_o), 32'd0);
    chk("rd.free", DATA_W'(free_cnt_o), 32'd8);

    // Dispatch bypass from a single channel
    set_disp(6'h01, 4'd4, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd5);
    set_cdb(2, 4'd7, 32'hAA);
    tick("byp.disp");
    idle();
    tick("byp.issue");
    chk("byp.en", DATA_W'(ALU_en_o), 32'd1);
    chk("byp.reg1", reg1_o, 32'hAA);
    tick("byp.done");

    // Dispatch bypass with two matching channels: lowest channel wins
    set_disp(6'h02, 4'd5, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd6);
    set_cdb(0, 4'd7, 32'h11);
    set_cdb(3, 4'd7, 32'h22);
    tick("byp2.disp");
    idle();
    tick("byp2.issue");
    chk("byp2.reg1", reg1_o, 32'h11);
    tick("byp2.done");

    // Wakeup of a stored entry with two matching channels
    set_disp(6'h03, 4'd6, 1'b0, 4'd9, 32'd0, 1'b0, 4'd9, 32'd0);
    tick("wk.disp");
    idle();
    set_cdb(1, 4'd9, 32'h33);
    set_cdb(2, 4'd9, 32'h44);
    tick("wk.wake");
    chk("wk.en_wait", DATA_W'(ALU_en_o), 32'd0);
    idle();
    tick("wk.issue");
    chk("wk.reg1", reg1_o, 32'h33);
    chk("wk.reg2", reg2_o, 32'h33);
    tick("wk.done");

    // Age order: A(e0), B(e1); B wakes first; D refills e1 before C refills e0
    set_disp(6'h10, 4'd10, 1'b0, 4'd1, 32'd0, 1'b1, 4'd0, 32'd1);
    tick("age.dA");
    set_disp(6'h11, 4'd11, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'd2);
    tick("age.dB");
    idle();
    set_cdb(0, 4'd2, 32'h0B);
    tick("age.wB");
    idle();
    set_cdb(0, 4'd1, 32'h0A);
    tick("age.iB");
    chk("age.first_B", DATA_W'(des_o), 32'd11);
    idle();
    set_disp(6'h13, 4'd13, 1'b0, 4'd4, 32'd0, 1'b1, 4'd0, 32'd4);
    tick("age.iA");
    chk("age.then_A", DATA_W'(des_o), 32'd10);
    set_disp(6'h12, 4'd12, 1'b0, 4'd3, 32'd0, 1'b1, 4'd0, 32'd3);
    tick("age.dC");
    idle();
    set_cdb(0, 4'd3, 32'h0C);
    set_cdb(1, 4'd4, 32'h0D);
    tick("age.wCD");
    idle();
    tick("age.iD");
    chk("age.D_first", DATA_W'(des_o), 32'd13);
    tick("age.iC");
    chk("age.C_second", DATA_W'(des_o), 32'd12);
    tick("age.done");

    // Fill while the ALU stalls, drop an extra dispatch, then drain in order
    alu_ready_i = 1'b0;
    for (int k = 0; k < 9; k++) begin
      set_disp(OP_W'(k + 8), TAG_W'(k), 1'b1, 4'd0, DATA_W'(100 + k), 1'b1, 4'd0, DATA_W'(200 + k));
      tick("full.fill");
    end
    chk("full.full", DATA_W'(full_o), 32'd1);
    chk("full.free0", DATA_W'(free_cnt_o), 32'd0);
    set_disp(6'h3F, 4'd15, 1'b1, 4'd0, 32'hDEAD, 1'b1, 4'd0, 32'hBEEF);
    tick("full.drop");
    chk("full.drop_free", DATA_W'(free_cnt_o), 32'd0);
    idle();
    for (int k = 0; k < 5; k++) begin
      tick("stall");
      chk("stall.en", DATA_W'(ALU_en_o), 32'd1);
      chk("stall.des", DATA_W'(des_o), 32'd0);
      chk("stall.reg1", reg1_o, 32'd100);
    end
    alu_ready_i = 1'b1;
    for (int k = 1; k < 9; k++) begin
      tick("drain.order");
      chk("drain.des", DATA_W'(des_o), DATA_W'(k));
    end
    tick("drain.empty");
    chk("drain.en_low", DATA_W'(ALU_en_o), 32'd0);
    chk("drain.free8", DATA_W'(free_cnt_o), 32'd8);

    // Freeze with rdy=0, then clear while frozen
    alu_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_disp(6'h20, TAG_W'(k), 1'b1, 4'd0, DATA_W'(k), 1'b1, 4'd0, DATA_W'(k));
      tick("clr.fill");
    end
    idle();
    chk("clr.free4", DATA_W'(free_cnt_o), 32'd4);
    rdy = 1'b0;
    alu_ready_i = 1'b1;
    set_disp(6'h21, 4'd9, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd1);
    tick("frz");
    chk("frz.free", DATA_W'(free_cnt_o), 32'd4);
    chk("frz.en", DATA_W'(ALU_en_o), 32'd1);
    we_i = 1'b0;
    clear = 1'b1;
    tick("clr");
    chk("clr.en", DATA_W'(ALU_en_o), 32'd0);
    chk("clr.free8", DATA_W'(free_cnt_o), 32'd8);
    idle();

    // Asynchronous reset mid-cycle
    set_disp(6'h2A, 4'd7, 1'b1, 4'd0, 32'h1234, 1'b1, 4'd0, 32'h5678);
    tick("ar.disp");
    set_disp(6'h2B, 4'd8, 1'b0, 4'd14, 32'd0, 1'b1, 4'd0, 32'd0);
    tick("ar.issue");
    chk("ar.en_pre", DATA_W'(ALU_en_o), 32'd1);
    chk("ar.free_pre", DATA_W'(free_cnt_o), 32'd7);
    idle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("ar.en", DATA_W'(ALU_en_o), 32'd0);
    chk("ar.reg1", reg1_o, 32'd0);
    chk("ar.op", DATA_W'(op_o), 32'd0);
    chk("ar.des", DATA_W'(des_o), 32'd0);
    chk("ar.free", DATA_W'(free_cnt_o), 32'd8);
    @(posedge clk);
    #1;
    check_outputs("ar.hold");
    rst = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      alu_ready_i = ($urandom_range(0, 3) != 0);
      we_i = ($urandom_range(0, 1) != 0);
      op_i = OP_W'($urandom);
      imm_i = $urandom;
      pc_i = $urandom;
      des_i = TAG_W'($urandom);
      reg1_valid_i = ($urandom_range(0, 1) != 0);
      reg2_valid_i = ($urandom_range(0, 1) != 0);
      reg1_tag_i = TAG_W'($urandom_range(0, 7));
      reg2_tag_i = TAG_W'($urandom_range(0, 7));
      reg1_data_i = $urandom;
      reg2_data_i = $urandom;
      cdb_en_i = '0;
      for (int k = 0; k < N_CDB; k++) begin
        if ($urandom_range(0, 2) == 0) set_cdb(k, TAG_W'($urandom_range(0, 7)), $urandom);
      end
      tick("rnd");
    end

    // Drain everything by broadcasting every tag
    idle();
    alu_ready_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      cdb_en_i = '0;
      for (int k = 0; k < N_CDB; k++) set_cdb(k, TAG_W'((n * N_CDB + k) % 16), $urandom);
      tick("fin.drain");
    end
    idle();
    for (int n = 0; n < 3; n++) tick("fin.idle");
    chk("fin.free8", DATA_W'(free_cnt_o), 32'd8);
    chk("fin.en_low", DATA_W'(ALU_en_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_rs_gen2.md
ALU_RS_GEN2 -- requirements
Module: alu_rs_gen2

Interface
REQ-001 Parameters, each given as name, default and meaning:
- DEPTH, 8: number of entries, minimum 2.
- N_CDB, 4: number of broadcast channels.
- TAG_W, 4: tag width.
- DATA_W, 32: data and address width.
- OP_W, 6: opcode width.

REQ-002 Ports, each given as name, direction, width and meaning:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global advance enable.
- clear  in  1  synchronous flush, for misprediction.
- we_i  in  1  dispatch request.
- op_i  in  OP_W  opcode.
- imm_i  in  DATA_W  immediate.
- pc_i  in  DATA_W  instruction PC.
- des_i  in  TAG_W  destination ROB tag.
- reg1_valid_i, reg2_valid_i  in  1  operand already available.
- reg1_tag_i, reg2_tag_i  in  TAG_W  producer tag when the operand is not valid.
- reg1_data_i, reg2_data_i  in  DATA_W  operand value when valid.
- cdb_en_i  in  N_CDB  per-channel broadcast valid.
- cdb_tag_i  in  N_CDB*TAG_W  packed tags; channel k occupies bits [k*TAG_W +: TAG_W].
- cdb_data_i  in  N_CDB*DATA_W  packed data, same packing as cdb_tag_i.
- alu_ready_i  in  1  ALU accepts the issue register.
- full_o  out  1  no free entry.
- free_cnt_o  out  $clog2(DEPTH+1)  number of free entries.
- ALU_en_o  out  1  issue valid.
- op_o, imm_o, pc_o, des_o  out  OP_W / DATA_W / DATA_W / TAG_W  issued payload.
- reg1_o, reg2_o  out  DATA_W  issued operand values.

Function
REQ-003 Each entry SHALL hold: valid, op, imm, pc, des, and for each of the two operands a valid bit, a tag and data, plus age ordering state.

REQ-004 free_cnt_o and full_o SHALL be combinational from registered entry state; full_o is 1 exactly when free_cnt_o equals 0.

REQ-005 A dispatch SHALL be accepted at a rising edge when rdy=1, clear=0, we_i=1 and full_o=0, and SHALL write the lowest-index entry that was free at the start of the cycle.

REQ-006 we_i=1 while full_o=1 SHALL be ignored with no state change; the upstream stage is responsible for checking full_o.

REQ-007 Dispatch bypass: an operand dispatched with valid=0 whose tag matches an enabled CDB channel in the same cycle SHALL be stored as valid with that channel's data.

REQ-008 Wakeup: a valid entry whose operand is not yet valid SHALL capture data from any enabled CDB channel with a matching tag and set the operand valid.

REQ-009 When several CDB channels match the same operand, the lowest-index channel SHALL win.

REQ-010 An entry is ready when it is valid and both operand valid bits are set in registered state, so wakeup at edge N makes the entry issuable at edge N+1.

REQ-011 Issue selection SHALL pick the oldest ready entry, where oldest means earliest accepted dispatch; there is no positional priority.

REQ-012 The issue register SHALL load when rdy=1 and (ALU_en_o=0 or alu_ready_i=1):
- ALU_en_o <= 1 and the payload <= the selected entry, with that entry freed at the same edge, when any entry is ready;
- ALU_en_o <= 0 otherwise, with the payload held.

REQ-013 Stall: while ALU_en_o=1 and alu_ready_i=0, the ALU_en_o signal and the payload SHALL hold and no entry SHALL issue; wakeup and dispatch SHALL continue.

REQ-014 Minimum latency from a dispatch with both operands valid at edge N SHALL be ALU_en_o=1 after edge N+1.

REQ-015 An entry freed by issue at edge N SHALL NOT be reused by a dispatch at edge N; it becomes available from edge N+1.

REQ-016 Simultaneous dispatch, wakeup and issue in one cycle SHALL all take effect, on distinct entries.

REQ-017 rdy=0 SHALL freeze all state and outputs, except that clear still acts.

REQ-018 clear=1 SHALL, at the edge, invalidate all entries, set ALU_en_o to 0 and reset the age state, regardless of rdy. It SHALL override dispatch, wakeup and issue in that cycle.

Reset
REQ-019 rst=1 SHALL asynchronously invalidate all entries, reset the age state and clear all outputs to 0; this gives free_cnt_o=DEPTH and full_o=0.

REQ-020 Entry payload fields other than the valid bits need not be reset.

Verification
REQ-021 Ready dispatch: dispatch op=0x05, reg1=10, reg2=20, both valid, des=3, alu_ready_i=1 -> one cycle later ALU_en_o=1, reg1_o=10, reg2_o=20, des_o=3; the following cycle ALU_en_o=0 and free_cnt_o=8.

REQ-022 Wakeup and bypass:
- Dispatch reg1 waiting on tag 7 while CDB channel 2 broadcasts tag 7 with data 0xAA -> the entry issues with reg1_o=0xAA.
- Same case but channel 0 broadcasts tag 7 with 0x11 and channel 3 broadcasts tag 7 with 0x22 -> reg1_o=0x11.

REQ-023 Age order: dispatch A into entry 0 and B into entry 1, both waiting. Wake B, then wake A at the same edge that B issues -> B issues first, then A. Refill entry 0 with C while entry 1 holds D; wake both in the same cycle -> D issues before C.

REQ-024 Full and stall: hold alu_ready_i=0 and fill 8 entries -> full_o=1 and free_cnt_o=0; a 9th we_i is dropped; payload is stable across 5 stalled cycles; releasing alu_ready_i drains all entries in dispatch order.

REQ-025 clear and reset: with 4 entries valid and ALU_en_o=1, pulse clear while rdy=0 -> next cycle ALU_en_o=0 and free_cnt_o=8. Assert rst mid-cycle -> outputs go to 0 immediately, before the next clock edge.
